wb_trace_fifo: RTL and testbench
================================

// Module: wb_trace_fifo
// PURPOSE
// - Downstream consumer of the mips core's retire-side write events: GRF writes from W and DM writes from M.
// - Packs each event into a trace record and buffers it in a FIFO.
// - A testbench or display consumer drains the FIFO over a valid/ready handshake.
// - Same-cycle events are kept in program order; overflow is reported, never silent.
// PARAMETERS
// - DEPTH   16  FIFO entries; power of two, >= 4
// - AW       4  log2(DEPTH); pointer width
// PORTS
// - clk        in   1   rising-edge clock, shared with mips
// - reset      in   1   synchronous, active-low; reset==0 at a rising edge clears the block
// - trace_en   in   1   1 = capture events; 0 = ignore event inputs
// - grf_we     in   1   GRF write strobe (W stage)
// - grf_addr   in   5   GRF destination register
// - grf_wdata  in  32   GRF write data
// - grf_pc     in  32   PC of the W-stage instruction
// - dm_we      in   1   DM write strobe (M stage)
// - dm_addr    in  32   DM byte address
// - dm_wdata   in  32   DM write data
// - dm_pc      in  32   PC of the M-stage instruction
// - rec_valid  out  1   head record available
// - rec_ready  in   1   consumer accepts the head record
// - rec_kind   out  1   0 = GRF, 1 = DM
// - rec_pc     out 32   record PC
// - rec_addr   out 32   GRF: {27'b0,grf_addr}; DM: dm_addr
// - rec_data   out 32   written data
// - count      out AW+1 occupied entries, 0..DEPTH
// - overflow   out  1   sticky: at least one event dropped
// - evt_total  out 32   accepted-event counter; wraps at 2^32
// BEHAVIOUR
// - Reset (reset==0 at posedge): wr_ptr=rd_ptr=0, count=0, overflow=0, evt_total=0.
//   - Outputs after reset: rec_valid=0; rec_kind/pc/addr/data=0.
//   - Storage contents need not be cleared.
//   - Reset mid-burst discards all entries and any same-cycle event or pop.
// - Event qualification: g_ev = trace_en & grf_we & (grf_addr!=0); d_ev = trace_en & dm_we.
//   - A write to $0 is never recorded.
// - Ordering: when g_ev and d_ev coincide, the GRF record is enqueued first.
//   - The W instruction is older than the M instruction.
//   - Up to 2 pushes per cycle.
// - Pop: pop = rec_valid & rec_ready; the head is consumed at that edge.
// - Space: free = DEPTH - count + pop. Space freed by a same-cycle pop is usable this cycle.
//   - free >= events: all events are accepted.
//   - free == 1 with 2 events: GRF accepted, DM dropped, overflow <= 1.
//   - free == 0: all events dropped; overflow <= 1 if any event was present.
// - Update per edge:
//   - count <= count + accepted - pop.
//   - wr_ptr advances by accepted; rd_ptr advances by pop; both wrap modulo DEPTH.
//   - evt_total += accepted.
// - Head read is first-word-fall-through. Accepted data appears on rec_* the edge after the push:
//   - rec_valid = (count != 0).
//   - rec_* = head entry when valid, else 0.
//   - rec_* hold steady while rec_valid & ~rec_ready.
// - A push into an empty FIFO with rec_ready=1 is not bypassed: 1-cycle latency minimum.
// - overflow clears only on reset. trace_en=0 suppresses capture only; draining continues.
// TESTING
// - Reset, then single GRF event:
//   - Stimulus: reset=0 for 2 cycles, release; grf_we=1, addr=8, wdata=0x1234, pc=0x3000, rec_ready=0.
//   - Response: next cycle rec_valid=1, kind=0, addr=8, data=0x1234, pc=0x3000, count=1.
// - Dual event in one cycle:
//   - Stimulus: grf (addr 2, data 5, pc 0x3004) and dm (addr 0x10, data 7, pc 0x3008) together.
//   - Response: count=2; first pop yields the GRF record, second the DM record; evt_total=2.
// - $0 and trace_en filtering:
//   - grf_we=1 with addr=0 -> no record.
//   - trace_en=0 with dm_we=1 -> no record.
//   - Both cases: count and evt_total unchanged.
// - Fill and overflow (DEPTH=16):
//   - Stimulus: 15 single events with rec_ready=0, then a dual event.
//   - Response: GRF accepted, count=16, overflow=1; a further event is dropped and count stays 16.
// - Full with simultaneous pop:
//   - Stimulus: count=16, rec_ready=1, single DM event.
//   - Response: head popped, DM accepted, count stays 16, overflow unchanged.
// - Reset mid-operation:
//   - Stimulus: count=5, assert reset=0 for one edge together with a dual event.
//   - Response: count=0, rec_valid=0, overflow=0, evt_total=0.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// Retire-side trace buffer: packs GRF (W) and DM (M) write events into records
// and queues them in a first-word-fall-through FIFO drained by valid/ready.
module wb_trace_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          trace_en,
   input  logic          grf_we,
   input  logic [4:0]    grf_addr,
   input  logic [31:0]   grf_wdata,
   input  logic [31:0]   grf_pc,
   input  logic          dm_we,
   input  logic [31:0]   dm_addr,
   input  logic [31:0]   dm_wdata,
   input  logic [31:0]   dm_pc,
   output logic          rec_valid,
   input  logic          rec_ready,
   output logic          rec_kind,
   output logic [31:0]   rec_pc,
   output logic [31:0]   rec_addr,
   output logic [31:0]   rec_data,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic [31:0]   evt_total
);

   localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

   // Record layout: {kind, pc, addr, data}
   logic [96:0]   mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [31:0]   evt_total_q, evt_total_d;

   logic          g_ev, d_ev, g_acc, d_acc, pop, drop;
   logic [AW+1:0] free;
   logic [1:0]    accepted;
   logic [96:0]   g_rec, d_rec, wd0, wd1, head;
   logic          we0, we1;
   logic [AW-1:0] wa0, wa1;

   always_comb begin
      g_ev     = trace_en & grf_we & (grf_addr != 5'd0);
      d_ev     = trace_en & dm_we;
      pop      = (count_q != '0) & rec_ready;
      free     = DEPTH_W - {1'b0, count_q} + {{(AW+1){1'b0}}, pop};
      // GRF (older W instruction) claims space first; DM needs a slot beyond it
      g_acc    = g_ev & (free != '0);
      d_acc    = d_ev & (free > {{(AW+1){1'b0}}, g_acc});
      accepted = {1'b0, g_acc} + {1'b0, d_acc};
      drop     = (g_ev & ~g_acc) | (d_ev & ~d_acc);

      g_rec    = {1'b0, grf_pc, {27'b0, grf_addr}, grf_wdata};
      d_rec    = {1'b1, dm_pc, dm_addr, dm_wdata};
      we0      = reset & (g_acc | d_acc);
      wd0      = g_acc ? g_rec : d_rec;
      wa0      = wr_ptr_q;
      we1      = reset & g_acc & d_acc;
      wd1      = d_rec;
      wa1      = wr_ptr_q + AW'(1);

      wr_ptr_d    = wr_ptr_q + AW'(accepted);
      rd_ptr_d    = rd_ptr_q + AW'(pop);
      count_d     = count_q + (AW+1)'(accepted) - (AW+1)'(pop);
      overflow_d  = overflow_q | drop;
      evt_total_d = evt_total_q + 32'(accepted);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         evt_total_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         evt_total_q <= evt_total_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we0) mem_q[wa0] <= wd0;
      if (we1) mem_q[wa1] <= wd1;
   end

   always_comb begin
      head      = mem_q[rd_ptr_q];
      rec_valid = (count_q != '0);
      {rec_kind, rec_pc, rec_addr, rec_data} = rec_valid ? head : '0;
      count     = count_q;
      overflow  = overflow_q;
      evt_total = evt_total_q;
   end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed plus randomized bench for wb_trace_fifo against a queue-based model.
module tb_wb_trace_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          reset, trace_en, grf_we, dm_we, rec_ready;
   logic [4:0]    grf_addr;
   logic [31:0]   grf_wdata, grf_pc, dm_addr, dm_wdata, dm_pc;
   logic          rec_valid, rec_kind, overflow;
   logic [31:0]   rec_pc, rec_addr, rec_data, evt_total;
   logic [AW:0]   count;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [96:0]   mq[$];
   logic          m_ovf;
   logic [31:0]   m_tot;

   always #5 clk = ~clk;

   wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .trace_en(trace_en),
      .grf_we(grf_we), .grf_addr(grf_addr), .grf_wdata(grf_wdata), .grf_pc(grf_pc),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
      .rec_pc(rec_pc), .rec_addr(rec_addr), .rec_data(rec_data),
      .count(count), .overflow(overflow), .evt_total(evt_total)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: reset clears; pop of old head frees space, events enqueue GRF then DM.
   task automatic model_edge();
      int space;
      bit pop;
      if (!reset) begin
         mq.delete();
         m_ovf = 1'b0;
         m_tot = '0;
         return;
      end
      pop   = (mq.size() != 0) && rec_ready;
      space = DEPTH - mq.size() + (pop ? 1 : 0);
      if (pop) void'(mq.pop_front());
      if (trace_en && grf_we && grf_addr != 0) begin
         if (space > 0) begin
            mq.push_back({1'b0, grf_pc, 27'b0, grf_addr, grf_wdata});
            space--; m_tot++;
         end else m_ovf = 1'b1;
      end
      if (trace_en && dm_we) begin
         if (space > 0) begin
            mq.push_back({1'b1, dm_pc, dm_addr, dm_wdata});
            space--; m_tot++;
         end else m_ovf = 1'b1;
      end
   endtask

   task automatic check_model();
      logic [96:0] exp_head;
      exp_head = (mq.size() != 0) ? mq[0] : '0;
      check("rec_valid", rec_valid, mq.size() != 0);
      check("rec", {rec_kind, rec_pc, rec_addr, rec_data}, exp_head);
      check("count", count, mq.size());
      check("overflow", overflow, m_ovf);
      check("evt_total", evt_total, m_tot);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic idle();
      reset = 1'b1; trace_en = 1'b1; grf_we = 1'b0; dm_we = 1'b0; rec_ready = 1'b0;
      grf_addr = '0; grf_wdata = '0; grf_pc = '0;
      dm_addr = '0; dm_wdata = '0; dm_pc = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic set_grf(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
      grf_we = 1'b1; grf_addr = a; grf_wdata = d; grf_pc = pc;
   endtask

   task automatic set_dm(input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
      dm_we = 1'b1; dm_addr = a; dm_wdata = d; dm_pc = pc;
   endtask

   initial begin
      idle();
      // reset and single GRF event
      do_reset();
      check("rst_valid", rec_valid, 1'b0);
      check("rst_rec", {rec_kind, rec_pc, rec_addr, rec_data}, 97'd0);
      check("rst_count", count, 5'd0);
      set_grf(5'd8, 32'h1234, 32'h3000);
      step();
      idle();
      check("g1_rec", {rec_valid, rec_kind, rec_addr, rec_data, rec_pc},
            {1'b1, 1'b0, 32'd8, 32'h1234, 32'h3000});
      check("g1_count", count, 5'd1);

      // dual event ordering
      do_reset();
      set_grf(5'd2, 32'd5, 32'h3004);
      set_dm(32'h10, 32'd7, 32'h3008);
      step();
      idle();
      check("dual_count", count, 5'd2);
      check("dual_head", {rec_kind, rec_addr, rec_data, rec_pc}, {1'b0, 32'd2, 32'd5, 32'h3004});
      rec_ready = 1'b1;
      step();
      check("dual_second", {rec_kind, rec_addr, rec_data, rec_pc}, {1'b1, 32'h10, 32'd7, 32'h3008});
      step();
      check("dual_empty", rec_valid, 1'b0);
      check("dual_total", evt_total, 32'd2);

      // $0 and trace_en filtering
      idle();
      set_grf(5'd0, 32'hdead, 32'h3010);
      step();
      idle();
      trace_en = 1'b0;
      set_dm(32'h20, 32'hbeef, 32'h3014);
      step();
      idle();
      check("filt_count", count, 5'd0);
      check("filt_total", evt_total, 32'd2);

      // fill and overflow
      do_reset();
      for (int i = 0; i < 15; i++) begin
         idle();
         if (i % 2 == 0) set_grf(5'(i + 1), 32'(i), 32'h4000 + 32'(4 * i));
         else set_dm(32'(i * 4), 32'(i), 32'h4000 + 32'(4 * i));
         step();
      end
      idle();
      check("fill15", count, 5'd15);
      check("fill15_ovf", overflow, 1'b0);
      set_grf(5'd3, 32'haaaa, 32'h5000);
      set_dm(32'h44, 32'hbbbb, 32'h5004);
      step();
      idle();
      check("full_count", count, 5'd16);
      check("full_ovf", overflow, 1'b1);
      check("full_total", evt_total, 32'd16);
      set_dm(32'h48, 32'hcccc, 32'h5008);
      step();
      idle();
      check("drop_count", count, 5'd16);

      // full with simultaneous pop
      rec_ready = 1'b1;
      set_dm(32'h4c, 32'hdddd, 32'h500c);
      step();
      idle();
      check("fullpop_count", count, 5'd16);
      check("fullpop_ovf", overflow, 1'b1);
      check("fullpop_total", evt_total, 32'd17);

      // reset mid-operation
      do_reset();
      for (int i = 0; i < 5; i++) begin
         idle();
         set_dm(32'(i), 32'(i + 100), 32'h6000);
         step();
      end
      idle();
      check("pre_rst_count", count, 5'd5);
      reset = 1'b0;
      set_grf(5'd9, 32'h99, 32'h7000);
      set_dm(32'h90, 32'h98, 32'h7004);
      step();
      idle();
      check("mid_rst", {rec_valid, count, overflow, evt_total}, 39'd0);

      // randomized traffic with shifting drain pressure
      for (int ph = 0; ph < 6; ph++) begin
         int unsigned rdy_pct;
         rdy_pct = (ph * 20) % 101;
         for (int c = 0; c < 300; c++) begin
            reset     = ($urandom_range(0, 199) != 0);
            trace_en  = ($urandom_range(0, 9) != 0);
            grf_we    = $urandom_range(0, 1);
            grf_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            grf_wdata = $urandom;
            grf_pc    = $urandom;
            dm_we     = $urandom_range(0, 1);
            dm_addr   = $urandom;
            dm_wdata  = $urandom;
            dm_pc     = $urandom;
            rec_ready = ($urandom_range(0, 99) < rdy_pct);
            step();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
